// File: rtl/bp_l15_resp_tracker.sv
// Tracks metadata for up to els_p outstanding L1.5 requests and pairs in-order
// L1.5 returns with it, holding each BP response in a per-channel register.
module bp_l15_resp_tracker #(
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 16,
  parameter int size_width_p    = 2,
  parameter int data_width_p    = 128,
  parameter int els_p           = 4,
  parameter int lg_els_lp       = $clog2(els_p) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       req_v_i,
  output logic                       req_ready_o,
  input  logic [paddr_width_p-1:0]   req_addr_i,
  input  logic [payload_width_p-1:0] req_payload_i,
  input  logic [size_width_p-1:0]    req_size_i,
  input  logic                       req_load_i,
  input  logic                       l15_val_i,
  input  logic [3:0]                 l15_returntype_i,
  input  logic [63:0]                l15_data_0_i,
  input  logic [63:0]                l15_data_1_i,
  output logic                       l15_ack_o,
  output logic                       resp_v_o,
  input  logic                       resp_ready_i,
  output logic [paddr_width_p-1:0]   resp_addr_o,
  output logic [payload_width_p-1:0] resp_payload_o,
  output logic [size_width_p-1:0]    resp_size_o,
  output logic                       data_resp_v_o,
  input  logic                       data_resp_ready_i,
  output logic [paddr_width_p-1:0]   data_resp_addr_o,
  output logic [payload_width_p-1:0] data_resp_payload_o,
  output logic [size_width_p-1:0]    data_resp_size_o,
  output logic [data_width_p-1:0]    data_resp_data_o,
  output logic [lg_els_lp-1:0]       outstanding_o,
  output logic                       err_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [3:0] LD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK = 4'b0100;
  localparam logic [lg_els_lp-1:0] full_cnt_lp = lg_els_lp'(els_p);

  typedef logic [ptr_w_lp-1:0] ptr_t;

  logic [paddr_width_p-1:0]   addr_mem_q    [els_p];
  logic [payload_width_p-1:0] payload_mem_q [els_p];
  logic [size_width_p-1:0]    size_mem_q    [els_p];
  logic [els_p-1:0]           load_mem_q;

  ptr_t                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [lg_els_lp-1:0] count_q, count_d;
  logic                 err_q, err_d;

  logic                       resp_v_q, resp_v_d;
  logic [paddr_width_p-1:0]   resp_addr_q, resp_addr_d;
  logic [payload_width_p-1:0] resp_payload_q, resp_payload_d;
  logic [size_width_p-1:0]    resp_size_q, resp_size_d;

  logic                       dresp_v_q, dresp_v_d;
  logic [paddr_width_p-1:0]   dresp_addr_q, dresp_addr_d;
  logic [payload_width_p-1:0] dresp_payload_q, dresp_payload_d;
  logic [size_width_p-1:0]    dresp_size_q, dresp_size_d;
  logic [data_width_p-1:0]    dresp_data_q, dresp_data_d;

  logic         is_ld, is_st, ld_room, st_room, empty, push, pop;
  logic         ack_ld, ack_st;
  logic [127:0] ret_data;

  assign is_ld    = (l15_returntype_i == LD_RET);
  assign is_st    = (l15_returntype_i == ST_ACK);
  assign ld_room  = ~dresp_v_q | data_resp_ready_i;
  assign st_room  = ~resp_v_q | resp_ready_i;
  assign empty    = (count_q == '0);
  assign ret_data = {l15_data_1_i, l15_data_0_i};

  // Unknown return types are always acked so they never stall the L1.5.
  assign l15_ack_o = reset_n_i & l15_val_i &
                     (is_ld ? ld_room : (is_st ? st_room : 1'b1));
  assign ack_ld    = l15_ack_o & is_ld;
  assign ack_st    = l15_ack_o & is_st;

  assign req_ready_o = (count_q != full_cnt_lp);
  assign push        = req_v_i & req_ready_o;
  // Emptiness is judged on the registered count: a same-cycle push cannot match.
  assign pop         = (ack_ld | ack_st) & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (push && !pop)      count_d = count_q + lg_els_lp'(1);
    else if (pop && !push) count_d = count_q - lg_els_lp'(1);
    if (req_v_i && !req_ready_o)                  err_d = 1'b1;
    if ((ack_ld || ack_st) && empty)              err_d = 1'b1;
    if (pop && (load_mem_q[rd_ptr_q] != ack_ld))  err_d = 1'b1;
  end

  always_comb begin
    resp_v_d       = resp_v_q;
    resp_addr_d    = resp_addr_q;
    resp_payload_d = resp_payload_q;
    resp_size_d    = resp_size_q;
    if (resp_v_q && resp_ready_i) begin
      resp_v_d       = 1'b0;
      resp_addr_d    = '0;
      resp_payload_d = '0;
      resp_size_d    = '0;
    end
    if (pop && ack_st) begin
      resp_v_d       = 1'b1;
      resp_addr_d    = addr_mem_q[rd_ptr_q];
      resp_payload_d = payload_mem_q[rd_ptr_q];
      resp_size_d    = size_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    dresp_v_d       = dresp_v_q;
    dresp_addr_d    = dresp_addr_q;
    dresp_payload_d = dresp_payload_q;
    dresp_size_d    = dresp_size_q;
    dresp_data_d    = dresp_data_q;
    if (dresp_v_q && data_resp_ready_i) begin
      dresp_v_d       = 1'b0;
      dresp_addr_d    = '0;
      dresp_payload_d = '0;
      dresp_size_d    = '0;
      dresp_data_d    = '0;
    end
    if (pop && ack_ld) begin
      dresp_v_d       = 1'b1;
      dresp_addr_d    = addr_mem_q[rd_ptr_q];
      dresp_payload_d = payload_mem_q[rd_ptr_q];
      dresp_size_d    = size_mem_q[rd_ptr_q];
      dresp_data_d    = ret_data[data_width_p-1:0];
    end
  end

  // Entry storage needs no reset: only slots below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem_q[wr_ptr_q]    <= req_addr_i;
      payload_mem_q[wr_ptr_q] <= req_payload_i;
      size_mem_q[wr_ptr_q]    <= req_size_i;
      load_mem_q[wr_ptr_q]    <= req_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      err_q           <= 1'b0;
      resp_v_q        <= 1'b0;
      resp_addr_q     <= '0;
      resp_payload_q  <= '0;
      resp_size_q     <= '0;
      dresp_v_q       <= 1'b0;
      dresp_addr_q    <= '0;
      dresp_payload_q <= '0;
      dresp_size_q    <= '0;
      dresp_data_q    <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      err_q           <= err_d;
      resp_v_q        <= resp_v_d;
      resp_addr_q     <= resp_addr_d;
      resp_payload_q  <= resp_payload_d;
      resp_size_q     <= resp_size_d;
      dresp_v_q       <= dresp_v_d;
      dresp_addr_q    <= dresp_addr_d;
      dresp_payload_q <= dresp_payload_d;
      dresp_size_q    <= dresp_size_d;
      dresp_data_q    <= dresp_data_d;
    end
  end

  assign resp_v_o            = resp_v_q;
  assign resp_addr_o         = resp_addr_q;
  assign resp_payload_o      = resp_payload_q;
  assign resp_size_o         = resp_size_q;
  assign data_resp_v_o       = dresp_v_q;
  assign data_resp_addr_o    = dresp_addr_q;
  assign data_resp_payload_o = dresp_payload_q;
  assign data_resp_size_o    = dresp_size_q;
  assign data_resp_data_o    = dresp_data_q;
  assign outstanding_o       = count_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_bp_l15_resp_tracker.sv
// Bench for bp_l15_resp_tracker: directed test-plan steps plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_bp_l15_resp_tracker;

  localparam logic [3:0] LD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK = 4'b0100;

  typedef struct packed {
    logic [39:0] addr;
    logic [15:0] pay;
    logic [1:0]  size;
    logic        load;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_v = 1'b0, req_load = 1'b0;
  logic [39:0]  req_addr = '0;
  logic [15:0]  req_pay = '0;
  logic [1:0]   req_size = '0;
  logic         l15_val = 1'b0;
  logic [3:0]   l15_type = 4'h0;
  logic [63:0]  d0 = '0, d1 = '0;
  logic         resp_ready = 1'b1, data_ready = 1'b1;

  logic         req_ready, l15_ack, resp_v, data_v, err;
  logic [39:0]  resp_addr, data_addr;
  logic [15:0]  resp_pay, data_pay;
  logic [1:0]   resp_size, data_size;
  logic [127:0] data_data;
  logic [2:0]   outstanding;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t         q[$];
  logic         m_rv, m_dv, m_err;
  ent_t         m_r, m_d;
  logic [127:0] m_dd;

  bp_l15_resp_tracker dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_payload_i(req_pay), .req_size_i(req_size), .req_load_i(req_load),
    .l15_val_i(l15_val), .l15_returntype_i(l15_type),
    .l15_data_0_i(d0), .l15_data_1_i(d1), .l15_ack_o(l15_ack),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_addr_o(resp_addr),
    .resp_payload_o(resp_pay), .resp_size_o(resp_size),
    .data_resp_v_o(data_v), .data_resp_ready_i(data_ready),
    .data_resp_addr_o(data_addr), .data_resp_payload_o(data_pay),
    .data_resp_size_o(data_size), .data_resp_data_o(data_data),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ack();
    if (!l15_val) return 1'b0;
    if (l15_type == LD_RET) return !m_dv || data_ready;
    if (l15_type == ST_ACK) return !m_rv || resp_ready;
    return 1'b1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_rv = 0; m_dv = 0; m_err = 0; m_r = '0; m_d = '0; m_dd = '0;
  endtask

  task automatic check_all();
    chk("req_ready", req_ready, q.size() != 4);
    chk("l15_ack", l15_ack, exp_ack());
    chk("outstanding", outstanding, q.size());
    chk("err", err, m_err);
    chk("resp_v", resp_v, m_rv);
    chk("resp_meta", {resp_addr, resp_pay, resp_size}, {m_r.addr, m_r.pay, m_r.size});
    chk("data_v", data_v, m_dv);
    chk("data_meta", {data_addr, data_pay, data_size}, {m_d.addr, m_d.pay, m_d.size});
    chk("data_data", data_data, m_dd);
  endtask

  // Advances the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic ack, room, ld;
    ent_t e;
    ack  = exp_ack();
    room = q.size() != 4;
    ld   = (l15_type == LD_RET);
    if (m_dv && data_ready) begin m_dv = 0; m_d = '0; m_dd = '0; end
    if (m_rv && resp_ready) begin m_rv = 0; m_r = '0; end
    if (ack && (ld || l15_type == ST_ACK)) begin
      if (q.size() == 0) m_err = 1;
      else begin
        e = q.pop_front();
        if (e.load != ld) m_err = 1;
        if (ld) begin m_dv = 1; m_d = e; m_dd = {d1, d0}; end
        else begin m_rv = 1; m_r = e; end
      end
    end
    if (req_v) begin
      if (!room) m_err = 1;
      else q.push_back('{addr: req_addr, pay: req_pay, size: req_size, load: req_load});
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_v = 0; l15_val = 0;
  endtask

  task automatic set_req(input logic [39:0] a, input logic [15:0] p,
                         input logic [1:0] s, input logic ld);
    req_v = 1; req_addr = a; req_pay = p; req_size = s; req_load = ld;
  endtask

  task automatic set_ret(input logic [3:0] t, input logic [63:0] hi, input logic [63:0] lo);
    l15_val = 1; l15_type = t; d1 = hi; d0 = lo;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset_n = 0; l15_val = 1; l15_type = LD_RET; req_v = 0;
    #1;
    chk("rst_resp_v", resp_v, 1'b0);
    chk("rst_data_v", data_v, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_ack", l15_ack, 1'b0);
    chk("rst_data", {data_data, data_addr, resp_addr}, '0);
    model_clear();
    l15_val = 0;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", req_ready, 1'b1);
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;

    // Single load, then an async reset with the response still held.
    set_req(40'h80_0000_1000, 16'h1A, 2'd3, 1'b1); cycle(); idle();
    set_ret(LD_RET, 64'hAAAA, 64'h5555); data_ready = 0; cycle(); idle();
    chk("single_ld_v", data_v, 1'b1);
    chk("single_ld_addr", data_addr, 40'h80_0000_1000);
    chk("single_ld_data", data_data, {64'hAAAA, 64'h5555});
    chk("single_ld_resp_v", resp_v, 1'b0);
    cycle();
    do_reset(); data_ready = 1;

    // Fill with 4 stores, overflow, drain in order.
    for (int i = 1; i <= 4; i++) begin
      set_req(40'h100 + 40'(i), 16'(i), 2'd1, 1'b0); cycle();
    end
    chk("full_ready", req_ready, 1'b0);
    chk("full_outstanding", outstanding, 3'd4);
    set_req(40'hDEAD, 16'h99, 2'd0, 1'b0); cycle(); idle();
    chk("overflow_err", err, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      set_ret(ST_ACK, '0, '0); cycle();
      chk("order_payload", resp_pay, 16'(i));
    end
    idle(); cycle(); cycle();
    do_reset();

    // Backpressure on the load channel.
    set_req(40'h2000, 16'h21, 2'd2, 1'b1); cycle();
    set_req(40'h2040, 16'h22, 2'd2, 1'b1); cycle(); idle();
    data_ready = 0;
    set_ret(LD_RET, 64'h11, 64'h22); cycle();
    set_ret(LD_RET, 64'h33, 64'h44); cycle();
    chk("bp_ack_low", l15_ack, 1'b0);
    cycle();
    chk("bp_hold_pay", data_pay, 16'h21);
    data_ready = 1; cycle(); idle();
    chk("bp_second_pay", data_pay, 16'h22);
    cycle(); cycle();

    // Ignored return type with one entry outstanding.
    set_req(40'h3000, 16'h31, 2'd0, 1'b0); cycle(); idle();
    set_ret(4'b0111, 64'h0, 64'h0); cycle(); idle();
    chk("ign_outstanding", outstanding, 3'd1);
    chk("ign_err", err, 1'b0);
    chk("ign_nov", {resp_v, data_v}, 2'b00);
    do_reset();

    // Store ack while empty, then a kind mismatch after reset.
    set_ret(ST_ACK, '0, '0); cycle(); idle();
    chk("empty_err", err, 1'b1);
    chk("empty_nov", resp_v, 1'b0);
    cycle();
    do_reset();
    set_req(40'h4000, 16'h41, 2'd1, 1'b1); cycle(); idle();
    set_ret(ST_ACK, '0, '0); cycle(); idle();
    chk("mm_err", err, 1'b1);
    chk("mm_resp_v", resp_v, 1'b1);
    chk("mm_resp_addr", resp_addr, 40'h4000);
    cycle();

    // Random traffic, with a reset partway through.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        req_v = ($urandom_range(0, 2) == 0);
        req_addr = {8'h0, $urandom()}; req_pay = 16'($urandom());
        req_size = 2'($urandom()); req_load = 1'($urandom());
        l15_val = ($urandom_range(0, 1) == 1);
        if (q.size() != 0 && $urandom_range(0, 9) < 8)
          l15_type = q[0].load ? LD_RET : ST_ACK;
        else
          case ($urandom_range(0, 2))
            0: l15_type = LD_RET;
            1: l15_type = ST_ACK;
            default: l15_type = 4'b0111;
          endcase
        d0 = {$urandom(), $urandom()}; d1 = {$urandom(), $urandom()};
        resp_ready = ($urandom_range(0, 3) != 0);
        data_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
